// File: rtl/apu_noise_gen.sv
// apu_noise_gen: NES-APU noise voice (register file, LFSR timer, length
// counter, envelope) producing a 4-bit sample for the mixer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   apu_cycle         APU-rate enable (CPU/2), clocks the period timer
//   qtrframe          envelope clock strobe
//   halfframe         length counter clock strobe
//   en                channel enable ($4015); low forces length to 0
//   apu_addr, data_in, apu_wr   register write bus (offsets 0xC, 0xE, 0xF)
//   active            registered: length counter != 0
//   lfsr_tick         registered one-clk pulse per LFSR shift
//   sample            registered voice output
//
// Configuration macro: APU_NOISE_SHORTMODE_EN
//   defined   -> mode bit selects TAP_SHORT feedback
//   undefined -> mode bit stored but ignored, TAP_LONG always used
module apu_noise_gen #(
  parameter int unsigned LFSR_W    = 15,
  parameter int unsigned TAP_LONG  = 1,
  parameter int unsigned TAP_SHORT = 6,
  parameter int unsigned REGION    = 0,
  parameter int unsigned DIV_W     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_cycle,
  input  logic       qtrframe,
  input  logic       halfframe,
  input  logic       en,
  input  logic [4:0] apu_addr,
  input  logic [7:0] data_in,
  input  logic       apu_wr,
  output logic       active,
  output logic       lfsr_tick,
  output logic [3:0] sample
);

  // Timer period in APU cycles for the selected region.
  function automatic logic [DIV_W-1:0] period_lut(input logic [3:0] idx);
    logic [11:0] p;
    p = 12'd0;
    if (REGION == 0) begin
      case (idx)
        4'd0:  p = 12'd2;    4'd1:  p = 12'd4;    4'd2:  p = 12'd8;    4'd3:  p = 12'd16;
        4'd4:  p = 12'd32;   4'd5:  p = 12'd48;   4'd6:  p = 12'd64;   4'd7:  p = 12'd80;
        4'd8:  p = 12'd101;  4'd9:  p = 12'd127;  4'd10: p = 12'd190;  4'd11: p = 12'd254;
        4'd12: p = 12'd381;  4'd13: p = 12'd508;  4'd14: p = 12'd1017; 4'd15: p = 12'd2034;
        default: p = 12'd2;
      endcase
    end else begin
      case (idx)
        4'd0:  p = 12'd2;    4'd1:  p = 12'd4;    4'd2:  p = 12'd7;    4'd3:  p = 12'd15;
        4'd4:  p = 12'd30;   4'd5:  p = 12'd44;   4'd6:  p = 12'd59;   4'd7:  p = 12'd74;
        4'd8:  p = 12'd94;   4'd9:  p = 12'd118;  4'd10: p = 12'd177;  4'd11: p = 12'd236;
        4'd12: p = 12'd354;  4'd13: p = 12'd472;  4'd14: p = 12'd945;  4'd15: p = 12'd1889;
        default: p = 12'd2;
      endcase
    end
    return DIV_W'(p);
  endfunction

  // Length counter load values.
  function automatic logic [7:0] len_lut(input logic [4:0] i);
    logic [7:0] v;
    v = 8'd0;
    case (i)
      5'd0:  v = 8'd10;  5'd1:  v = 8'd254; 5'd2:  v = 8'd20;  5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;  5'd5:  v = 8'd4;   5'd6:  v = 8'd80;  5'd7:  v = 8'd6;
      5'd8:  v = 8'd160; 5'd9:  v = 8'd8;   5'd10: v = 8'd60;  5'd11: v = 8'd10;
      5'd12: v = 8'd14;  5'd13: v = 8'd12;  5'd14: v = 8'd26;  5'd15: v = 8'd14;
      5'd16: v = 8'd12;  5'd17: v = 8'd16;  5'd18: v = 8'd24;  5'd19: v = 8'd18;
      5'd20: v = 8'd48;  5'd21: v = 8'd20;  5'd22: v = 8'd96;  5'd23: v = 8'd22;
      5'd24: v = 8'd192; 5'd25: v = 8'd24;  5'd26: v = 8'd72;  5'd27: v = 8'd26;
      5'd28: v = 8'd16;  5'd29: v = 8'd28;  5'd30: v = 8'd32;  5'd31: v = 8'd30;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  logic              halt_q, halt_d;
  logic              const_q, const_d;
  logic [3:0]        vol_q, vol_d;
  logic              mode_q, mode_d;
  logic [3:0]        idx_q, idx_d;
  logic              start_q, start_d;
  logic [7:0]        len_q, len_d;
  logic [3:0]        decay_q, decay_d;
  logic [3:0]        div_q, div_d;
  logic [DIV_W-1:0]  timer_q, timer_d;
  logic [LFSR_W-1:0] sr_q, sr_d;
  logic              tick_q, tick_d;
  logic              active_q, active_d;
  logic [3:0]        sample_q, sample_d;
  logic              wr_len;
  logic              fb;

`ifdef APU_NOISE_SHORTMODE_EN
  assign fb = sr_q[0] ^ (mode_q ? sr_q[TAP_SHORT] : sr_q[TAP_LONG]);
`else
  // Early silicon: mode bit is kept in the register file but has no effect.
  logic unused_mode;
  assign unused_mode = mode_q;
  assign fb = sr_q[0] ^ sr_q[TAP_LONG];
`endif

  assign wr_len = apu_wr && (apu_addr == 5'h0F);

  // Next-state logic for registers, timer, LFSR, length and envelope.
  always_comb begin
    halt_d   = halt_q;
    const_d  = const_q;
    vol_d    = vol_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    start_d  = start_q;
    len_d    = len_q;
    decay_d  = decay_q;
    div_d    = div_q;
    timer_d  = timer_q;
    sr_d     = sr_q;
    tick_d   = 1'b0;

    if (apu_wr) begin
      case (apu_addr)
        5'h0C: begin
          halt_d  = data_in[5];
          const_d = data_in[4];
          vol_d   = data_in[3:0];
        end
        5'h0E: begin
          mode_d = data_in[7];
          idx_d  = data_in[3:0];
        end
        default: ;
      endcase
    end

    // Period index is only sampled at reload, so mid-count changes wait.
    if (apu_cycle) begin
      if (timer_q == '0) begin
        timer_d = period_lut(idx_q) - DIV_W'(1);
        sr_d    = {fb, sr_q[LFSR_W-1:1]};
        tick_d  = 1'b1;
      end else begin
        timer_d = timer_q - DIV_W'(1);
      end
    end

    // Load has priority over a coincident halfframe decrement.
    if (!en) begin
      len_d = 8'd0;
    end else if (wr_len) begin
      len_d = len_lut(data_in[7:3]);
    end else if (halfframe && (len_q != 8'd0) && !halt_q) begin
      len_d = len_q - 8'd1;
    end

    if (qtrframe) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = 4'hF;
        div_d   = vol_q;
      end else if (div_q == 4'd0) begin
        div_d = vol_q;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (halt_q) begin
          decay_d = 4'hF;
        end
      end else begin
        div_d = div_q - 4'd1;
      end
    end

    // A fresh 0xF write re-arms the envelope even if qtrframe just consumed it.
    if (wr_len) begin
      start_d = 1'b1;
    end

    active_d = (len_q != 8'd0);
    sample_d = (!sr_q[0] && (len_q != 8'd0)) ? (const_q ? vol_q : decay_q) : 4'd0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q   <= 1'b0;
      const_q  <= 1'b0;
      vol_q    <= 4'd0;
      mode_q   <= 1'b0;
      idx_q    <= 4'd0;
      start_q  <= 1'b0;
      len_q    <= 8'd0;
      decay_q  <= 4'd0;
      div_q    <= 4'd0;
      timer_q  <= '0;
      sr_q     <= LFSR_W'(1);
      tick_q   <= 1'b0;
      active_q <= 1'b0;
      sample_q <= 4'd0;
    end else begin
      halt_q   <= halt_d;
      const_q  <= const_d;
      vol_q    <= vol_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      len_q    <= len_d;
      decay_q  <= decay_d;
      div_q    <= div_d;
      timer_q  <= timer_d;
      sr_q     <= sr_d;
      tick_q   <= tick_d;
      active_q <= active_d;
      sample_q <= sample_d;
    end
  end

  assign active    = active_q;
  assign lfsr_tick = tick_q;
  assign sample    = sample_q;

endmodule

// File: tb/tb_apu_noise_gen.sv
// Bench for apu_noise_gen: directed vector table plus hand-written
// sequences for length, envelope, period change and LFSR period.
module tb_apu_noise_gen;

  logic       clk;
  logic       rst;
  logic       apu_cycle;
  logic       qtrframe;
  logic       halfframe;
  logic       en;
  logic [4:0] apu_addr;
  logic [7:0] data_in;
  logic       apu_wr;
  logic       active;
  logic       lfsr_tick;
  logic [3:0] sample;
  logic       pal_active;
  logic       pal_tick;
  logic [3:0] pal_sample;

  int n_tests = 0;
  int n_fail  = 0;

  apu_noise_gen u_dut (
    .clk(clk), .rst(rst), .apu_cycle(apu_cycle), .qtrframe(qtrframe),
    .halfframe(halfframe), .en(en), .apu_addr(apu_addr), .data_in(data_in),
    .apu_wr(apu_wr), .active(active), .lfsr_tick(lfsr_tick), .sample(sample)
  );

  apu_noise_gen #(.REGION(1)) u_pal (
    .clk(clk), .rst(rst), .apu_cycle(apu_cycle), .qtrframe(qtrframe),
    .halfframe(halfframe), .en(en), .apu_addr(apu_addr), .data_in(data_in),
    .apu_wr(apu_wr), .active(pal_active), .lfsr_tick(pal_tick), .sample(pal_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
    logic       en;
    logic       apu;
    logic       tick;
    logic       act;
    logic [3:0] smp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; apu_cycle = 1'b0; qtrframe = 1'b0; halfframe = 1'b0;
    en = 1'b0; apu_addr = 5'd0; data_in = 8'd0; apu_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
    apu_wr = 1'b1; apu_addr = a; data_in = d;
    @(negedge clk);
    apu_wr = 1'b0;
  endtask

  task automatic pulse_half();
    halfframe = 1'b1;
    @(negedge clk);
    halfframe = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_qtr();
    qtrframe = 1'b1;
    @(negedge clk);
    qtrframe = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Runs the LFSR from seed 1 until the DUT register returns to 1.
  task automatic run_lfsr(input logic [7:0] e_val, input int tap,
                          output int ticks, output int bad);
    logic [14:0] model;
    do_reset();
    wr_reg(5'h0E, e_val);
    model = 15'd1;
    ticks = 0;
    bad   = 0;
    apu_cycle = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      if (lfsr_tick) begin
        ticks++;
        model = {model[0] ^ model[tap], model[14:1]};
        if (u_dut.sr_q !== model) bad++;
        if (u_dut.sr_q == 15'd1) break;
      end
    end
    apu_cycle = 1'b0;
  endtask

  // Envelope from a fresh start; loop_en selects wrap-around expectation.
  task automatic env_run(input logic [7:0] c_val, input logic loop_en);
    int m;
    int exp;
    do_reset();
    en = 1'b1;
    wr_reg(5'h0C, c_val);
    wr_reg(5'h0F, 8'h08);
    apu_cycle = 1'b1;
    @(negedge clk);
    apu_cycle = 1'b0;
    for (int n = 1; n <= 55; n++) begin
      pulse_qtr();
      m = (n - 1) / 3;
      if (loop_en) exp = 15 - (m % 16);
      else         exp = (m >= 15) ? 0 : 15 - m;
      check($sformatf("env%0d n=%0d", loop_en, n), int'(sample), exp);
    end
  endtask

  initial begin
    int ticks;
    int bad;
    int tn[3];
    int tp[3];
    int nn;
    int np;
    int cnt;

    vecs[0]  = '{1'b1, 5'h0E, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 5'h0C, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{1'b1, 5'h0F, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[4]  = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0};
    vecs[5]  = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF};
    vecs[6]  = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF};
    vecs[7]  = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF};
    vecs[8]  = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF};
    vecs[9]  = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF};
    vecs[10] = '{1'b1, 5'h0C, 8'h15, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF};
    vecs[11] = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5};
    vecs[12] = '{1'b1, 5'h0D, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5};
    vecs[13] = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5};
    vecs[14] = '{1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5};
    vecs[15] = '{1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[16] = '{1'b1, 5'h0F, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[17] = '{1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};

    rst = 1'b1; apu_cycle = 1'b0; qtrframe = 1'b0; halfframe = 1'b0;
    en = 1'b0; apu_addr = 5'd0; data_in = 8'd0; apu_wr = 1'b0;

    // Reset state
    do_reset();
    check("rst_active", int'(active), 0);
    check("rst_tick", int'(lfsr_tick), 0);
    check("rst_sample", int'(sample), 0);

    // Vector table: one row per clock, outputs checked after the edge
    for (int i = 0; i < 18; i++) begin
      apu_wr = vecs[i].wr; apu_addr = vecs[i].addr; data_in = vecs[i].data;
      en = vecs[i].en; apu_cycle = vecs[i].apu;
      @(negedge clk);
      check($sformatf("vec%0d_tick", i), int'(lfsr_tick), int'(vecs[i].tick));
      check($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].act));
      check($sformatf("vec%0d_sample", i), int'(sample), int'(vecs[i].smp));
    end
    apu_wr = 1'b0; apu_cycle = 1'b0;

    // Length counter: 254 halfframes to expire
    do_reset();
    en = 1'b1;
    wr_reg(5'h0C, 8'h10);
    wr_reg(5'h0F, 8'h08);
    @(negedge clk);
    @(negedge clk);
    check("len_loaded", int'(active), 1);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      pulse_half();
      cnt++;
      if (!active) break;
    end
    check("len_254_halfframes", cnt, 254);
    wr_reg(5'h0F, 8'h08);
    @(negedge clk);
    @(negedge clk);
    check("len_reload", int'(active), 1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("en_kill", int'(active), 0);

    // Coincident 0xF write and halfframe: load (2) wins
    do_reset();
    en = 1'b1;
    wr_reg(5'h0C, 8'h10);
    halfframe = 1'b1;
    wr_reg(5'h0F, 8'h18);
    halfframe = 1'b0;
    pulse_half();
    check("coinc_len1", int'(active), 1);
    pulse_half();
    check("coinc_len0", int'(active), 0);

    // Envelope decay and loop
    env_run(8'h02, 1'b0);
    env_run(8'h22, 1'b1);

    // Period index change mid-count, NTSC and PAL side by side
    do_reset();
    en = 1'b1;
    wr_reg(5'h0E, 8'h00);
    apu_cycle = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (lfsr_tick) begin
        cnt = 1;
        break;
      end
    end
    check("first_tick_seen", cnt, 1);
    apu_wr = 1'b1; apu_addr = 5'h0E; data_in = 8'h0F;
    nn = 0; np = 0;
    tn = '{default: -1};
    tp = '{default: -1};
    for (int c = 1; c <= 4300; c++) begin
      @(negedge clk);
      apu_wr = 1'b0;
      if (lfsr_tick && nn < 3) begin tn[nn] = c; nn++; end
      if (pal_tick && np < 3) begin tp[np] = c; np++; end
    end
    apu_cycle = 1'b0;
    check("ntsc_old_period", tn[0], 2);
    check("ntsc_gap1", tn[1] - tn[0], 2034);
    check("ntsc_gap2", tn[2] - tn[1], 2034);
    check("pal_old_period", tp[0], 2);
    check("pal_gap1", tp[1] - tp[0], 1889);
    check("pal_gap2", tp[2] - tp[1], 1889);

    // Long-mode LFSR period from seed 1
    run_lfsr(8'h00, 1, ticks, bad);
    check("lfsr_long_period", ticks, 32767);
    check("lfsr_long_seq", bad, 0);

`ifdef APU_NOISE_SHORTMODE_EN
    run_lfsr(8'h80, 6, ticks, bad);
    check("lfsr_short_period", ticks, 93);
    check("lfsr_short_seq", bad, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apu_noise_gen.md
# apu_noise_gen

Parametrised NES-APU noise voice, successor to the fixed-width noise channel. Combines the register file, an LFSR timer with selectable NTSC/PAL period tables, and an integrated length counter and envelope with loop support. Sits in the APU beside the pulse and triangle voices. Consumes the APU register write bus and frame-sequencer strobes, and produces a 4-bit sample for the mixer.

## Interface
Parameters:
- LFSR_W, 15: shift-register width (≥8)
- TAP_LONG, 1: feedback tap in long mode
- TAP_SHORT, 6: feedback tap in short mode (< LFSR_W)
- REGION, 0: period table, 0 = NTSC, 1 = PAL
- DIV_W, 11: timer counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- apu_cycle  in  1  APU-rate enable (CPU/2)
- qtrframe  in  1  envelope clock strobe
- halfframe  in  1  length clock strobe
- en  in  1  channel enable from $4015
- apu_addr  in  5  register offset
- data_in  in  8  write data
- apu_wr  in  1  write strobe
- active  out  1  length counter ≠ 0
- lfsr_tick  out  1  one-clk pulse on each LFSR shift
- sample  out  4  voice output

## Operation
- Writes when apu_wr is high:
  - addr 0xC: [5] halt/loop, [4] const, [3:0] vol/env period
  - addr 0xE: [7] mode, [3:0] period index
  - addr 0xF: [7:3] length index; also sets the envelope start flag
  - Other addresses are ignored.
- Timer:
  - The counter decrements on each apu_cycle.
  - On apu_cycle with counter==0, it reloads to table[idx]−1 and shifts the LFSR.
  - A new period index takes effect only at the next reload.
- NTSC table (apu cycles): 2,4,8,16,32,48,64,80,101,127,190,254,381,508,1017,2034.
- PAL table (apu cycles): 2,4,7,15,30,44,59,74,94,118,177,236,354,472,945,1889.
- LFSR:
  - Shift operation: fb = sr[0] ^ sr[mode ? TAP_SHORT : TAP_LONG]; sr ← {fb, sr[LFSR_W−1:1]}.
  - lfsr_tick pulses in the same cycle as the shift.
- Length counter:
  - Load table: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - Loaded on a 0xF write only while en=1.
  - On halfframe, decrements if nonzero and halt=0.
  - en=0 forces it to 0.
  - A 0xF write and halfframe in the same cycle: the load wins.
- Envelope, on qtrframe:
  - If the start flag is set: clear the flag, decay←15, div←period.
  - Otherwise, if div==0: div←period, and decay decrements if nonzero. If decay is already 0 and loop (halt bit) is set, decay←15.
  - Otherwise div decrements.
- sample = (sr[0]==0 && length≠0) ? (const ? vol : decay) : 0.

## Timing
- Reset values:
  - sr = 1
  - All registers, length, decay, div, start flag and timer counter = 0
  - Outputs: sample=0, active=0, lfsr_tick=0
- Register writes land at the clock edge. Derived state changes at the next edge that sees the strobe.
- sample and active are registered: one clk after the state they reflect.
- Strobes (apu_cycle, qtrframe, halfframe) are single-clk pulses. Coincident strobes are each honoured in the same cycle.
- rst mid-operation restores all reset values on the next edge, with no partial shift.

## Configuration
- APU_NOISE_SHORTMODE_EN:
  - Defined: the mode bit selects TAP_SHORT (93-step sequence for the defaults).
  - Undefined: the mode bit is stored but ignored, and TAP_LONG is always used, matching early 2A03 silicon.

## Test plan
- Reset, period idx 0 NTSC, 0xC=0x1F (const, vol 15), en=1, 0xF=0x08 -> lfsr_tick every 2 apu_cycles. First shift gives sr=0x4000, and sample=15 after it.
- Long mode from seed 1 -> sr returns to 0x0001 after exactly 32767 shifts. Short mode (macro defined) -> returns after 93 shifts.
- en=1, 0xC=0x10, 0xF=0x08 (len 254) -> active high for 254 halfframes, then 0. Deasserting en at any point -> active=0 next cycle.
- 0xC=0x02, 0xF write -> first qtrframe gives decay=15. Decay then drops by 1 every 3 qtrframes and holds at 0. With 0xC=0x22, decay wraps 0→15.
- Change period idx 0→15 mid-count -> the old period completes, then ticks occur every 2034 apu_cycles. With REGION=1 idx 15 -> every 1889.
- A 0xF write coincident with halfframe, halt=0 -> the length equals the loaded value, not value−1.
